// File: rtl/mux_rr_select.sv
// Round-robin select controller for a 4-to-1 mux. It drives the mux select, holds a grant for
// up to BURST transfers, and presents one valid/ready handshake toward the mux consumer.
module mux_rr_select #(
    parameter int unsigned BURST = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] ch_valid,
    input  logic       out_ready,
    output logic [1:0] s,
    output logic       out_valid,
    output logic [3:0] ch_ready,
    output logic       busy
);

    typedef enum logic {StIdle, StGrant} state_e;

    localparam logic [3:0] BurstLen = 4'(BURST);

    state_e     state_q, state_d;
    logic [1:0] s_q, s_d;
    logic [1:0] ptr_q, ptr_d;
    logic [3:0] cnt_q, cnt_d;
    logic [1:0] win, idx;
    logic       found;
    logic       sel_valid;
    logic       xfer;

    // First requesting channel at or after the pointer, wrapping mod 4.
    always_comb begin
        win   = ptr_q;
        found = 1'b0;
        idx   = ptr_q;
        for (int i = 0; i < 4; i++) begin
            idx = ptr_q + 2'(i);
            if (!found && ch_valid[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    assign sel_valid = ch_valid[s_q];
    assign xfer      = sel_valid & out_ready;

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    s_d     = win;
                    cnt_d   = 4'd0;
                    state_d = StGrant;
                end
            end
            StGrant: begin
                // A dropped valid ends the burst early; a stall just holds.
                if (!sel_valid) begin
                    state_d = StIdle;
                    ptr_d   = s_q + 2'd1;
                end else if (xfer) begin
                    if (cnt_q + 4'd1 == BurstLen) begin
                        state_d = StIdle;
                        ptr_d   = s_q + 2'd1;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            s_q     <= 2'd0;
            ptr_q   <= 2'd0;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign s         = s_q;
    assign busy      = (state_q == StGrant);
    assign out_valid = busy & sel_valid;
    assign ch_ready  = (busy && out_ready) ? (4'b0001 << s_q) : 4'b0000;

endmodule

// File: doc/mux_rr_select.md
# mux_rr_select

Round-robin select controller that sits directly upstream of the 4-to-1 8-bit multiplexer and drives its 2-bit select `s`. Four source channels present data to mux inputs a/b/c/d with a valid/ready handshake. This block arbitrates between them, holds the selection for a bounded burst, and exposes a single valid/ready handshake toward the consumer of the mux output `y`. Data never passes through this block; only the select and handshake signals do.

## Interface
- `BURST`, default 4: maximum transfers per grant, legal range 1..15.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ch_valid`  in  4  per-channel valid; bit i corresponds to mux input a/b/c/d for i = 0/1/2/3.
- `out_ready`  in  1  downstream consumer accepts `y` this cycle.
- `s`  out  2  select to the mux; registered.
- `out_valid`  out  1  the mux output `y` carries a valid beat.
- `ch_ready`  out  4  per-channel ready; at most one bit is set.
- `busy`  out  1  high while in GRANT.

## Operation
- Reset values: `s` = 0, internal pointer `ptr` = 0, burst count = 0, state = IDLE, `out_valid` = 0, `ch_ready` = 0, `busy` = 0.
- **State IDLE:**
  - If `ch_valid` is nonzero, choose the first channel with valid set, scanning `ptr`, `ptr`+1, … mod 4.
  - Register the winner into `s`, clear the count, and go to GRANT.
  - If `ch_valid` is zero, stay in IDLE; `s` holds its previous value.
- **State GRANT:**
  - `out_valid` = `ch_valid[s]`.
  - `ch_ready` = onehot(`s`) & {4{`out_ready`}}.
  - Both outputs are combinational from registered `s`/state and the live inputs.
  - A transfer occurs when `ch_valid[s]` && `out_ready`.
  - Each transfer increments the 4-bit count.
- **Release GRANT → IDLE,** with `ptr` ← `s`+1 mod 4, when either:
  - a transfer occurs and count+1 == `BURST`, or
  - `ch_valid[s]` is 0 in a GRANT cycle.
  - A stall (`ch_valid[s]`=1, `out_ready`=0) holds the grant indefinitely and does not advance the count.
- `s` never changes while in GRANT.
- `out_valid` and `ch_ready` are 0 in IDLE.
- Other channels' valid bits are ignored during GRANT.
- `BURST`=1: release after every transfer, which gives strict per-beat rotation.
- Pointer wrap: `s`=3 sets `ptr`=0.
- `rst_n` asserted mid-burst clears all state immediately, asynchronously. An in-flight beat is not completed. After reset, arbitration restarts from channel 0.

## Timing
- Arbitration latency: valid seen in IDLE at edge N; `s` and `busy` update at edge N; first possible transfer in cycle N+1.
- Release costs one IDLE bubble cycle. Back-to-back grants therefore have ≥1 cycle with `out_valid`=0.
- Maximum throughput is `BURST`/(`BURST`+1) beats per cycle under continuous valid.
- No combinational path from `ch_valid` to `s`.
- Combinational paths exist from `ch_valid[s]` to `out_valid` and from `out_ready` to `ch_ready`.

## Test plan
- Reset: hold `rst_n`=0 with `ch_valid`=4'b1111 → `s`=0, `out_valid`=0, `ch_ready`=0, `busy`=0. Release reset → channel 0 granted one cycle later.
- Burst limit: `BURST`=4, `ch_valid`=4'b0001, `out_ready`=1 continuously → 4 transfers with `ch_ready`=4'b0001, 1 idle cycle, then channel 0 regranted. The repeating pattern is 4 on / 1 off.
- Round-robin fairness: `BURST`=1, `ch_valid`=4'b1111, `out_ready`=1 → `s` sequence 0,1,2,3,0… with one bubble between grants. Each channel gets 1 beat per 8 cycles.
- Skip and wrap: `ptr`=3, `ch_valid`=4'b0101 → channel 0 granted next, then channel 2. Channels 1 and 3 are never readied.
- Stall and early release: grant channel 2, `out_ready`=0 for 5 cycles → `s`=2, count stays 0, `ch_ready`=0. Then drop `ch_valid[2]` → GRANT exits to IDLE, `ptr`=3.
- Reset mid-burst: assert `rst_n`=0 after 2 of 4 transfers on channel 1 → all outputs 0 within the same cycle, asynchronously. After release, arbitration resumes with `ptr`=0.
